// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - sequencer state enum, FFT size helper and bit-reverse function
package fft_pkg;

  // Widest transform supported; bit_rev works on this width and shifts down
  localparam int unsigned FFT_N_LOG2_MAX = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_UNLOAD = 3'd3,
    ST_FINISH = 3'd4
  } fft_state_e;

  // Number of points N = 1 << n_log2
  function automatic int unsigned fft_n(input int unsigned n_log2);
    return 32'd1 << n_log2;
  endfunction

  // Reverse the low nbits of v (upper bits of the result are zero)
  function automatic logic [FFT_N_LOG2_MAX-1:0] bit_rev(
    input logic [FFT_N_LOG2_MAX-1:0] v,
    input int unsigned               nbits
  );
    logic [FFT_N_LOG2_MAX-1:0] full;
    full = '0;
    for (int i = 0; i < FFT_N_LOG2_MAX; i++) begin
      full[i] = v[FFT_N_LOG2_MAX-1-i];
    end
    return full >> (FFT_N_LOG2_MAX - nbits);
  endfunction

endpackage

// File: rtl/addr_delay_line.sv
// rtl/addr_delay_line.sv - fixed-depth shift register with async active-low clear
module addr_delay_line #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr_q [DEPTH];
  logic [WIDTH-1:0] sr_d [DEPTH];

  // Advance every entry one slot; slot 0 takes the new input
  always_comb begin
    sr_d[0] = d;
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  // Register the line; reset wipes all in-flight entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_q[i] <= sr_d[i];
      end
    end
  end

  assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/fft_addr_sequencer.sv
// rtl/fft_addr_sequencer.sv - radix-2 DIF FFT read/write-back address sequencer (option: FFT_SEQ_UNLOAD_EN)
module fft_addr_sequencer
  import fft_pkg::*;
#(
  parameter  int unsigned N_LOG2         = 5,
  parameter  int unsigned ADDR_SIZE      = N_LOG2,
  parameter  int unsigned TWID_ADDR_SIZE = N_LOG2 - 1,
  parameter  int unsigned RD_LATENCY     = 3,
  localparam int unsigned STAGE_W        = $clog2(N_LOG2 + 1)
) (
  input  logic                      i_CLK,
  input  logic                      i_RST_N,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_rden,
  output logic [ADDR_SIZE-1:0]      o_rdaddr_A,
  output logic [ADDR_SIZE-1:0]      o_rdaddr_B,
  output logic [TWID_ADDR_SIZE-1:0] o_rdaddr_tw,
  output logic                      o_wren,
  output logic [ADDR_SIZE-1:0]      o_wraddr_A,
  output logic [ADDR_SIZE-1:0]      o_wraddr_B,
  output logic [STAGE_W-1:0]        o_stage
);

  localparam int unsigned N     = fft_n(N_LOG2);
  localparam int unsigned HALF  = N / 2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned DLY_W = 1 + 2 * ADDR_SIZE;

  fft_state_e                state_q, state_d;
  logic [N_LOG2-1:0]         b_q, b_d;
  logic [STAGE_W-1:0]        stage_q, stage_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      rden_q, rden_d;
  logic                      bfly_q, bfly_d;
  logic [ADDR_SIZE-1:0]      rd_a_q, rd_a_d;
  logic [ADDR_SIZE-1:0]      rd_b_q, rd_b_d;
  logic [TWID_ADDR_SIZE-1:0] rd_tw_q, rd_tw_d;
  logic [N_LOG2-1:0]         span, pos, grp, a_addr;
  logic [DLY_W-1:0]          dly_out;

  // State, counters and every output are flops so reset clears them at once
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q <= ST_IDLE;
      b_q     <= '0;
      stage_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rden_q  <= 1'b0;
      bfly_q  <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      rd_tw_q <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rden_q  <= rden_d;
      bfly_q  <= bfly_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      rd_tw_q <= rd_tw_d;
    end
  end

  // Walk butterflies within a stage, drain RD_LATENCY cycles, then advance stage
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_READ;
          b_d     = '0;
          stage_d = '0;
        end
      end
      ST_READ: begin
        if (b_q == N_LOG2'(HALF - 1)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          b_d = b_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(RD_LATENCY - 1)) begin
          if (stage_q == STAGE_W'(N_LOG2 - 1)) begin
`ifdef FFT_SEQ_UNLOAD_EN
            state_d = ST_UNLOAD;
            b_d     = '0;
`else
            state_d = ST_FINISH;
`endif
          end else begin
            state_d = ST_READ;
            stage_d = stage_q + 1'b1;
            b_d     = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef FFT_SEQ_UNLOAD_EN
      ST_UNLOAD: begin
        if (b_q == N_LOG2'(N - 1)) begin
          state_d = ST_FINISH;
        end else begin
          b_d = b_q + 1'b1;
        end
      end
`endif
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next-cycle outputs: butterfly addresses from stage/b via shifts and masks
  always_comb begin
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_FINISH);
    rden_d  = 1'b0;
    bfly_d  = 1'b0;
    rd_a_d  = rd_a_q;
    rd_b_d  = rd_b_q;
    rd_tw_d = rd_tw_q;
    span    = N_LOG2'(1) << (N_LOG2 - 1 - 32'(stage_d));
    pos     = b_d & (span - 1'b1);
    grp     = b_d >> (N_LOG2 - 1 - 32'(stage_d));
    a_addr  = (grp << (N_LOG2 - 32'(stage_d))) | pos;
    if (state_d == ST_READ) begin
      rden_d  = 1'b1;
      bfly_d  = 1'b1;
      rd_a_d  = ADDR_SIZE'(a_addr);
      rd_b_d  = ADDR_SIZE'(a_addr | span);
      rd_tw_d = TWID_ADDR_SIZE'(pos << 32'(stage_d));
    end
`ifdef FFT_SEQ_UNLOAD_EN
    if (state_d == ST_UNLOAD) begin
      rden_d  = 1'b1;
      rd_a_d  = ADDR_SIZE'(bit_rev(FFT_N_LOG2_MAX'(b_d), N_LOG2));
      rd_b_d  = '0;
      rd_tw_d = '0;
    end
`endif
  end

  addr_delay_line #(
    .DEPTH (RD_LATENCY),
    .WIDTH (DLY_W)
  ) u_wb_delay (
    .clk   (i_CLK),
    .rst_n (i_RST_N),
    .d     ({bfly_q, rd_a_q, rd_b_q}),
    .q     (dly_out)
  );

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_rden      = rden_q;
  assign o_rdaddr_A  = rd_a_q;
  assign o_rdaddr_B  = rd_b_q;
  assign o_rdaddr_tw = rd_tw_q;
  assign o_stage     = stage_q;
  assign o_wren      = dly_out[DLY_W-1];
  assign o_wraddr_A  = dly_out[2*ADDR_SIZE-1:ADDR_SIZE];
  assign o_wraddr_B  = dly_out[ADDR_SIZE-1:0];

endmodule

// File: tb/tb_fft_addr_sequencer.sv
// tb/tb_fft_addr_sequencer.sv - randomized start/reset stimulus checked against a cycle-index model
`timescale 1ns/1ps
module tb_fft_addr_sequencer #(
  parameter int N_LOG2     = 3,
  parameter int RD_LATENCY = 2
);

  localparam int AW   = N_LOG2;
  localparam int TW   = N_LOG2 - 1;
  localparam int SW   = $clog2(N_LOG2 + 1);
  localparam int N    = 1 << N_LOG2;
  localparam int HALF = N / 2;
  localparam int PER  = HALF + RD_LATENCY;
  localparam int RDEND = N_LOG2 * PER;
`ifdef FFT_SEQ_UNLOAD_EN
  localparam int UL = N;
`else
  localparam int UL = 0;
`endif
  localparam int TOTAL = RDEND + UL + 1;

  logic          i_CLK;
  logic          i_RST_N;
  logic          i_start;
  logic          o_busy, o_done, o_rden, o_wren;
  logic [AW-1:0] o_rdaddr_A, o_rdaddr_B, o_wraddr_A, o_wraddr_B;
  logic [TW-1:0] o_rdaddr_tw;
  logic [SW-1:0] o_stage;

  fft_addr_sequencer #(
    .N_LOG2         (N_LOG2),
    .ADDR_SIZE      (AW),
    .TWID_ADDR_SIZE (TW),
    .RD_LATENCY     (RD_LATENCY)
  ) dut (
    .i_CLK       (i_CLK),
    .i_RST_N     (i_RST_N),
    .i_start     (i_start),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_rden      (o_rden),
    .o_rdaddr_A  (o_rdaddr_A),
    .o_rdaddr_B  (o_rdaddr_B),
    .o_rdaddr_tw (o_rdaddr_tw),
    .o_wren      (o_wren),
    .o_wraddr_A  (o_wraddr_A),
    .o_wraddr_B  (o_wraddr_B),
    .o_stage     (o_stage)
  );

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  int total_cnt;
  int bad_cnt;
  int cyc;
  int m_t;
  int h_a, h_b, h_tw, h_stage;
  int blen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s cyc=%0d t=%0d got=%0d exp=%0d", tag, cyc, m_t, got, exp);
    end
  endtask

  // Butterfly index read at transform cycle t, or -1 when t is not a read cycle
  function automatic int rd_bf(input int t);
    int r;
    if (t < 1 || t > RDEND) return -1;
    r = (t - 1) % PER;
    return (r < HALF) ? r : -1;
  endfunction

  function automatic int rd_st(input int t);
    return (t - 1) / PER;
  endfunction

  function automatic int span_of(input int s);
    return N >> (s + 1);
  endfunction

  function automatic int addr_a(input int s, input int b);
    int sp;
    sp = span_of(s);
    return (b / sp) * 2 * sp + (b % sp);
  endfunction

  function automatic int brev(input int k);
    int r;
    r = 0;
    for (int i = 0; i < N_LOG2; i++) begin
      if (((k >> i) & 1) != 0) r = r + (1 << (N_LOG2 - 1 - i));
    end
    return r;
  endfunction

  function automatic bit in_unload(input int t);
    return (UL > 0) && (t > RDEND) && (t <= RDEND + UL);
  endfunction

  task automatic model_reset();
    m_t = 0; h_a = 0; h_b = 0; h_tw = 0; h_stage = 0; blen = 0;
  endtask

  task automatic model_step(input logic st);
    int b, s;
    if (m_t == 0) m_t = st ? 1 : 0;
    else if (m_t < TOTAL) m_t = m_t + 1;
    else m_t = 0;
    b = rd_bf(m_t);
    if (b >= 0) begin
      s    = rd_st(m_t);
      h_a  = addr_a(s, b);
      h_b  = h_a + span_of(s);
      h_tw = (b % span_of(s)) * (1 << s);
      if (b == 0) h_stage = s;
    end else if (in_unload(m_t)) begin
      h_a  = brev(m_t - RDEND - 1);
      h_b  = 0;
      h_tw = 0;
    end
  endtask

  task automatic compare_all();
    int b, wb, ws;
    b  = rd_bf(m_t);
    wb = (m_t - RD_LATENCY >= 1) ? rd_bf(m_t - RD_LATENCY) : -1;
    chk("rden",  32'(o_rden), 32'((b >= 0) || in_unload(m_t)));
    chk("rdA",   32'(o_rdaddr_A), h_a);
    chk("rdB",   32'(o_rdaddr_B), h_b);
    chk("rdTW",  32'(o_rdaddr_tw), h_tw);
    chk("stage", 32'(o_stage), h_stage);
    chk("wren",  32'(o_wren), 32'(wb >= 0));
    if (wb >= 0) begin
      ws = rd_st(m_t - RD_LATENCY);
      chk("wrA", 32'(o_wraddr_A), addr_a(ws, wb));
      chk("wrB", 32'(o_wraddr_B), addr_a(ws, wb) + span_of(ws));
    end
    chk("busy", 32'(o_busy), 32'(m_t != 0));
    chk("done", 32'(o_done), 32'(m_t == TOTAL));
    if (o_busy) blen++;
    else if (blen > 0) begin
      chk("busy_len", blen, TOTAL);
      blen = 0;
    end
  endtask

  task automatic step(input logic st);
    i_start = st;
    @(posedge i_CLK);
    model_step(st);
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic do_reset(input int hold);
    i_RST_N = 1'b0;
    i_start = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (hold) begin
      @(posedge i_CLK);
      cyc++;
      #1;
      compare_all();
    end
    i_RST_N = 1'b1;
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    cyc       = 0;
    i_RST_N   = 1'b0;
    i_start   = 1'b0;
    model_reset();
    #1;
    do_reset(2);

    // single pulse: full transform then idle
    step(1'b1);
    repeat (TOTAL + 4) step(1'b0);

    // start held high across several transforms
    repeat (2 * TOTAL + 4) step(1'b1);
    repeat (TOTAL + 2) step(1'b0);

    // reset at transform cycle 8, then no writes without a new start
    step(1'b1);
    repeat (7) step(1'b0);
    do_reset(2);
    repeat (30) step(1'b0);

    // random start pulses with occasional async resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset(int'($urandom_range(0, 2)));
      else step($urandom_range(0, 5) == 0);
    end
    repeat (TOTAL + 2) step(1'b0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
